// File: rtl/pipeline_run_controller_pkg.sv
// Shared state encoding and default sizing for the pipeline run controller.
package pipeline_run_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int DRAIN_CYCLES_DEF     = 3;
  localparam int CYCLE_COUNT_BITS_DEF = 32;

endpackage

// File: rtl/pipeline_run_controller_if.sv
// Debug-command, hazard and pipeline-enable signals seen by the run controller.
interface pipeline_run_controller_if #(
  parameter int CYCLE_COUNT_BITS = 32
);
  logic i_start_cont;
  logic i_start_step;
  logic i_step;
  logic i_abort;
  logic i_halt_detected;
  logic i_hazard_PCWrite;
  logic i_hazard_if_id_write;
  logic o_pipeline_enable;
  logic o_PCWrite;
  logic o_if_id_write;
  logic o_fetch_kill;
  logic o_running;
  logic o_step_mode;
  logic o_done;
  logic o_halted;
  logic [CYCLE_COUNT_BITS-1:0] o_cycle_count;

  modport master (
    output i_start_cont, i_start_step, i_step, i_abort,
           i_halt_detected, i_hazard_PCWrite, i_hazard_if_id_write,
    input  o_pipeline_enable, o_PCWrite, o_if_id_write, o_fetch_kill,
           o_running, o_step_mode, o_done, o_halted, o_cycle_count
  );

  modport slave (
    input  i_start_cont, i_start_step, i_step, i_abort,
           i_halt_detected, i_hazard_PCWrite, i_hazard_if_id_write,
    output o_pipeline_enable, o_PCWrite, o_if_id_write, o_fetch_kill,
           o_running, o_step_mode, o_done, o_halted, o_cycle_count
  );
endinterface

// File: rtl/pipeline_run_controller_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module pipeline_run_controller_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             gclk,
  input  logic             grst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)                count <= '0;
    else if (clr)               count <= '0;
    else if (en && !(&count))   count <= count + WIDTH'(1);
  end
endmodule

// File: rtl/pipeline_run_controller.sv
// Run/step/drain sequencer for the five-stage pipeline; gates hazard-unit
// write enables with a global pipeline enable and counts enabled cycles.
module pipeline_run_controller
  import pipeline_run_controller_pkg::*;
#(
  parameter int CYCLE_COUNT_BITS = CYCLE_COUNT_BITS_DEF,
  parameter int DRAIN_CYCLES     = DRAIN_CYCLES_DEF
) (
  input logic                      i_clock,
  input logic                      i_reset,
  pipeline_run_controller_if.slave bus
);
  localparam int DW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

  state_e        state;
  logic          step_mode;
  logic          token;
  logic          done_q;
  logic          halted_q;
  logic [DW-1:0] drain_cnt;

  logic active, enable, halt_q, fetch_kill, start_ok, drain_last;

  assign active     = (state == ST_RUN) || (state == ST_DRAIN);
  assign enable     = active && (!step_mode || token) && !bus.i_abort;
  // A HALT stalled in ID is not accepted until the IF/ID register actually moves.
  assign halt_q     = bus.i_halt_detected && bus.i_hazard_if_id_write && enable;
  assign fetch_kill = enable && (halt_q || (state == ST_DRAIN));
  assign start_ok   = (state == ST_IDLE) && !bus.i_abort &&
                      (bus.i_start_cont || bus.i_start_step);
  assign drain_last = (drain_cnt == DW'(1));

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state     <= ST_IDLE;
      step_mode <= 1'b0;
      token     <= 1'b0;
      drain_cnt <= '0;
      done_q    <= 1'b0;
      halted_q  <= 1'b0;
    end else if (bus.i_abort) begin
      state     <= ST_IDLE;
      token     <= 1'b0;
      drain_cnt <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // One-shot token: a step request lasts exactly one enabled cycle, no queuing.
      token  <= !token && step_mode && active && bus.i_step;
      case (state)
        ST_IDLE: begin
          if (bus.i_start_cont) begin
            state     <= ST_RUN;
            step_mode <= 1'b0;
            halted_q  <= 1'b0;
          end else if (bus.i_start_step) begin
            state     <= ST_RUN;
            step_mode <= 1'b1;
            halted_q  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (halt_q) begin
            if (DRAIN_CYCLES == 0) begin
              state    <= ST_DONE;
              done_q   <= 1'b1;
              halted_q <= 1'b1;
            end else begin
              state     <= ST_DRAIN;
              drain_cnt <= DW'(DRAIN_CYCLES);
            end
          end
        end
        ST_DRAIN: begin
          if (enable) begin
            drain_cnt <= drain_cnt - DW'(1);
            if (drain_last) begin
              state    <= ST_DONE;
              done_q   <= 1'b1;
              halted_q <= 1'b1;
            end
          end
        end
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  pipeline_run_controller_sat_counter #(.WIDTH(CYCLE_COUNT_BITS)) u_cycle_cnt (
    .gclk   (i_clock),
    .grst_n (i_reset),
    .clr    (start_ok),
    .en     (enable),
    .count  (bus.o_cycle_count)
  );

  assign bus.o_pipeline_enable = enable;
  assign bus.o_fetch_kill      = fetch_kill;
  assign bus.o_PCWrite         = enable && bus.i_hazard_PCWrite && !fetch_kill;
  assign bus.o_if_id_write     = enable && (bus.i_hazard_if_id_write || fetch_kill);
  assign bus.o_running         = active;
  assign bus.o_step_mode       = step_mode;
  assign bus.o_done            = done_q;
  assign bus.o_halted          = halted_q;

endmodule

// File: tb/tb_pipeline_run_controller.sv
// Scoreboard bench: every enabled or done cycle the DUT shows is matched
// against a queued, hand-computed expectation.
module tb_pipeline_run_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipeline_run_controller_if #(.CYCLE_COUNT_BITS(32)) bus ();
  pipeline_run_controller_if #(.CYCLE_COUNT_BITS(4))  bus4 ();

  pipeline_run_controller #(.CYCLE_COUNT_BITS(32), .DRAIN_CYCLES(3)) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  pipeline_run_controller #(.CYCLE_COUNT_BITS(4), .DRAIN_CYCLES(3)) dut4 (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus4)
  );

  typedef struct {
    string       name;
    logic        en, fk, pcw, ifw, done, halted;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input string n, input logic en, input logic fk, input logic pcw,
                      input logic ifw, input logic done, input logic halted, input int cnt);
    exp_t e;
    e.name = n; e.en = en; e.fk = fk; e.pcw = pcw; e.ifw = ifw;
    e.done = done; e.halted = halted; e.cnt = 32'(cnt);
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: anything the DUT presents (enabled cycle or done pulse) must be expected.
  always @(negedge clk) begin
    if (rst_n && (bus.o_pipeline_enable || bus.o_done)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: en=%0b done=%0b with empty scoreboard at %0t",
                 bus.o_pipeline_enable, bus.o_done, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, ".enable"},     32'(bus.o_pipeline_enable), 32'(e.en));
        chk({e.name, ".fetch_kill"}, 32'(bus.o_fetch_kill),      32'(e.fk));
        chk({e.name, ".PCWrite"},    32'(bus.o_PCWrite),         32'(e.pcw));
        chk({e.name, ".if_id_write"},32'(bus.o_if_id_write),     32'(e.ifw));
        chk({e.name, ".done"},       32'(bus.o_done),            32'(e.done));
        chk({e.name, ".halted"},     32'(bus.o_halted),          32'(e.halted));
        chk({e.name, ".count"},      bus.o_cycle_count,          e.cnt);
      end
    end
  end

  task automatic set_hazards(input logic pcw, input logic ifw);
    bus.i_hazard_PCWrite     = pcw;
    bus.i_hazard_if_id_write = ifw;
  endtask

  initial begin
    bus.i_start_cont = 0; bus.i_start_step = 0; bus.i_step = 0; bus.i_abort = 0;
    bus.i_halt_detected = 0; set_hazards(0, 0);
    bus4.i_start_cont = 0; bus4.i_start_step = 0; bus4.i_step = 0; bus4.i_abort = 0;
    bus4.i_halt_detected = 0; bus4.i_hazard_PCWrite = 0; bus4.i_hazard_if_id_write = 0;

    // Reset state
    #12;
    chk("rst.enable",  32'(bus.o_pipeline_enable), 0);
    chk("rst.PCWrite", 32'(bus.o_PCWrite), 0);
    chk("rst.if_id",   32'(bus.o_if_id_write), 0);
    chk("rst.kill",    32'(bus.o_fetch_kill), 0);
    chk("rst.running", 32'(bus.o_running), 0);
    chk("rst.step",    32'(bus.o_step_mode), 0);
    chk("rst.done",    32'(bus.o_done), 0);
    chk("rst.halted",  32'(bus.o_halted), 0);
    chk("rst.count",   bus.o_cycle_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Step pulses in IDLE do nothing
    for (int c = 0; c < 4; c++) begin
      bus.i_step = (c % 2 == 0);
      @(negedge clk);
      chk("idle_step.enable", 32'(bus.o_pipeline_enable), 0);
      tick();
    end
    bus.i_step = 0;
    set_hazards(1, 1);

    // Continuous run, HALT on 10th enabled cycle, 3-cycle drain
    bus.i_start_cont = 1;
    tick();
    bus.i_start_cont = 0;
    for (int k = 1; k <= 14; k++) begin
      bus.i_halt_detected = (k == 10);
      bus.i_start_cont    = (k == 14);
      if (k < 10)      push("run",   1, 0, 1, 1, 0, 0, k - 1);
      else if (k < 14) push("drain", 1, 1, 0, 1, 0, 0, k - 1);
      else             push("done",  0, 0, 0, 0, 1, 1, 13);
      tick();
    end
    bus.i_start_cont = 0;
    bus.i_halt_detected = 0;
    @(negedge clk);
    chk("cont.count",   bus.o_cycle_count, 13);
    chk("cont.halted",  32'(bus.o_halted), 1);
    chk("cont.running", 32'(bus.o_running), 0);
    tick();

    // Step mode: steps at cycles 5, 6, 9 -> enabled at 6 and 10
    bus.i_start_step = 1;
    tick();
    bus.i_start_step = 0;
    for (int c = 1; c <= 11; c++) begin
      bus.i_step = (c == 5) || (c == 6) || (c == 9);
      if (c == 6)  push("step6",  1, 0, 1, 1, 0, 0, 0);
      if (c == 10) push("step10", 1, 0, 1, 1, 0, 0, 1);
      tick();
    end
    bus.i_step = 0;
    @(negedge clk);
    chk("step.count",   bus.o_cycle_count, 2);
    chk("step.mode",    32'(bus.o_step_mode), 1);
    chk("step.running", 32'(bus.o_running), 1);
    tick();
    bus.i_abort = 1;
    tick();
    bus.i_abort = 0;
    @(negedge clk);
    chk("step_abort.running", 32'(bus.o_running), 0);
    tick();

    // HALT held by a stall is not accepted until the stall releases
    bus.i_start_cont = 1;
    tick();
    bus.i_start_cont = 0;
    for (int k = 1; k <= 8; k++) begin
      case (k)
        1: begin set_hazards(1, 1); bus.i_halt_detected = 0; push("pre_stall", 1, 0, 1, 1, 0, 0, 0); end
        2, 3: begin set_hazards(0, 0); bus.i_halt_detected = 1; push("stall", 1, 0, 0, 0, 0, 0, k - 1); end
        4: begin set_hazards(1, 1); bus.i_halt_detected = 1; push("released", 1, 1, 0, 1, 0, 0, 3); end
        8: begin bus.i_halt_detected = 0; push("stall_done", 0, 0, 0, 0, 1, 1, 7); end
        default: begin bus.i_halt_detected = 0; push("stall_drain", 1, 1, 0, 1, 0, 0, k - 1); end
      endcase
      tick();
    end
    tick();

    // Abort in DRAIN with counter==2
    bus.i_start_cont = 1;
    tick();
    bus.i_start_cont = 0;
    bus.i_halt_detected = 1;
    push("ab_halt", 1, 1, 0, 1, 0, 0, 0);
    tick();
    bus.i_halt_detected = 0;
    push("ab_drain", 1, 1, 0, 1, 0, 0, 1);
    tick();
    bus.i_abort = 1;
    @(negedge clk);
    chk("abort.enable", 32'(bus.o_pipeline_enable), 0);
    chk("abort.kill",   32'(bus.o_fetch_kill), 0);
    tick();
    bus.i_abort = 0;
    repeat (3) tick();
    @(negedge clk);
    chk("abort.running", 32'(bus.o_running), 0);
    chk("abort.count",   bus.o_cycle_count, 2);
    chk("abort.halted",  32'(bus.o_halted), 0);
    tick();
    bus.i_start_cont = 1;
    tick();
    bus.i_start_cont = 0;
    push("restart", 1, 0, 1, 1, 0, 0, 0);
    tick();
    bus.i_abort = 1;
    tick();
    bus.i_abort = 0;
    tick();

    // Simultaneous starts: continuous wins
    bus.i_start_cont = 1;
    bus.i_start_step = 1;
    tick();
    bus.i_start_cont = 0;
    bus.i_start_step = 0;
    push("both_start", 1, 0, 1, 1, 0, 0, 0);
    @(negedge clk);
    chk("both.step_mode", 32'(bus.o_step_mode), 0);
    tick();
    bus.i_abort = 1;
    tick();
    bus.i_abort = 0;
    tick();

    // Asynchronous reset in the middle of a drain
    bus.i_start_cont = 1;
    tick();
    bus.i_start_cont = 0;
    bus.i_halt_detected = 1;
    push("rr_halt", 1, 1, 0, 1, 0, 0, 0);
    tick();
    bus.i_halt_detected = 0;
    push("rr_drain", 1, 1, 0, 1, 0, 0, 1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("async_rst.enable",  32'(bus.o_pipeline_enable), 0);
    chk("async_rst.running", 32'(bus.o_running), 0);
    chk("async_rst.kill",    32'(bus.o_fetch_kill), 0);
    chk("async_rst.count",   bus.o_cycle_count, 0);
    #2;
    rst_n = 1'b1;
    tick();

    // Saturation on the 4-bit instance
    bus4.i_start_cont = 1;
    tick();
    bus4.i_start_cont = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 16) begin
        @(negedge clk);
        chk("sat.count_at_16", 32'(bus4.o_cycle_count), 15);
      end
      tick();
    end
    @(negedge clk);
    chk("sat.count_at_21", 32'(bus4.o_cycle_count), 15);
    chk("sat.enable",      32'(bus4.o_pipeline_enable), 1);
    tick();
    bus4.i_abort = 1;
    tick();
    bus4.i_abort = 0;
    tick();

    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
